// File: rtl/dcache_responder_if.sv
// dcache_responder_if
//   Request/response bundle between the core's data port and the data-memory
//   responder. Signal names follow the core-side naming.
//   master : core side (drives the request, receives the response)
//   slave  : responder side (receives the request, drives the response)
//   core2dcache_req/addr/data/data_we/data_size : request strobe and payload
//   dcache2core_data/data_valid/err             : one-cycle response
//   dcache_busy                                 : high while a request is pending
interface dcache_responder_if;
    logic        core2dcache_req;
    logic [31:0] core2dcache_addr;
    logic [63:0] core2dcache_data;
    logic        core2dcache_data_we;
    logic [1:0]  core2dcache_data_size;
    logic [63:0] dcache2core_data;
    logic        dcache2core_data_valid;
    logic        dcache2core_err;
    logic        dcache_busy;

    modport master (
        output core2dcache_req, core2dcache_addr, core2dcache_data,
               core2dcache_data_we, core2dcache_data_size,
        input  dcache2core_data, dcache2core_data_valid, dcache2core_err, dcache_busy
    );

    modport slave (
        input  core2dcache_req, core2dcache_addr, core2dcache_data,
               core2dcache_data_we, core2dcache_data_size,
        output dcache2core_data, dcache2core_data_valid, dcache2core_err, dcache_busy
    );
endinterface

// File: rtl/dcache_responder.sv
// dcache_responder
//   Memory-side responder for the core's data-cache port. Services one load or
//   store at a time from a DEPTH x 64-bit array and answers LATENCY cycles
//   after accepting the request.
//   clock : single clock, all state changes on posedge
//   reset : synchronous, active low
//   bus   : dcache_responder_if.slave request/response bundle
module dcache_responder #(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2
) (
    input  logic                clock,
    input  logic                reset,
    dcache_responder_if.slave   bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;
    localparam logic [31:0]   ADDR_LIMIT = 32'(DEPTH * 8);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    addr_q, addr_d;
    logic [63:0]    wdata_q, wdata_d;
    logic           we_q, we_d;
    logic [1:0]     size_q, size_d;
    logic [63:0]    rdata_q, rdata_d;
    logic           err_q, err_d;
    logic           accept;
    logic           enter_resp;

    logic [63:0]    mem [DEPTH];

    // With LATENCY==1 the array is accessed on the very edge that accepts the
    // request, so the live bus payload is used instead of the latched copy.
    logic [31:0]    acc_addr;
    logic [63:0]    acc_wdata;
    logic           acc_we;
    logic [1:0]     acc_size;

    assign acc_addr  = (LATENCY == 1) ? bus.core2dcache_addr      : addr_q;
    assign acc_wdata = (LATENCY == 1) ? bus.core2dcache_data      : wdata_q;
    assign acc_we    = (LATENCY == 1) ? bus.core2dcache_data_we   : we_q;
    assign acc_size  = (LATENCY == 1) ? bus.core2dcache_data_size : size_q;

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        size_d  = size_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: if (bus.core2dcache_req) accept = 1'b1;
            WAIT: begin
                // req is ignored here: not queued, not acknowledged
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else             state_d = RESP;
            end
            RESP: begin
                if (bus.core2dcache_req) accept = 1'b1;
                else                     state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            addr_d  = bus.core2dcache_addr;
            wdata_d = bus.core2dcache_data;
            we_d    = bus.core2dcache_data_we;
            size_d  = bus.core2dcache_data_size;
            if (LATENCY == 1) begin
                state_d = RESP;
            end else begin
                state_d = WAIT;
                cnt_d   = CNT_INIT;
            end
        end
    end

    // Every transition into RESP (including RESP->RESP at LATENCY==1) is a
    // fresh access.
    assign enter_resp = (state_d == RESP);

    // ---------------- access datapath ----------------
    logic [2:0]     off;
    logic [5:0]     sh;
    logic [IW-1:0]  idx;
    logic           misalign, acc_err;
    logic [63:0]    size_mask, load_val, wdata_sh;
    logic [7:0]     be;

    assign off = acc_addr[2:0];
    assign sh  = {off, 3'b000};
    assign idx = acc_addr[3 +: IW];

    always_comb begin
        misalign  = 1'b0;
        size_mask = '1;
        be        = 8'hFF;
        case (acc_size)
            2'd0: begin misalign = 1'b0;           size_mask = 64'hFF;        be = 8'h01; end
            2'd1: begin misalign = acc_addr[0];    size_mask = 64'hFFFF;      be = 8'h03; end
            2'd2: begin misalign = |acc_addr[1:0]; size_mask = 64'hFFFF_FFFF; be = 8'h0F; end
            default: begin misalign = |acc_addr[2:0]; size_mask = '1;       be = 8'hFF; end
        endcase
        be = be << off;
    end

    assign acc_err  = misalign | (acc_addr >= ADDR_LIMIT);
    assign load_val = (mem[idx] >> sh) & size_mask;
    assign wdata_sh = acc_wdata << sh;
    assign rdata_d  = (!acc_we && !acc_err) ? load_val : '0;
    assign err_d    = acc_err;

    // ---------------- state registers ----------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            size_q  <= size_d;
            if (enter_resp) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    // Array is never cleared; a reset on the would-be write edge drops the store.
    always_ff @(posedge clock) begin
        if (reset && enter_resp && acc_we && !acc_err) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    // ---------------- outputs ----------------
    assign bus.dcache2core_data_valid = (state_q == RESP);
    assign bus.dcache2core_data       = (state_q == RESP) ? rdata_q : '0;
    assign bus.dcache2core_err        = (state_q == RESP) && err_q;
    assign bus.dcache_busy            = (state_q == WAIT);
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder
//   Directed bench for dcache_responder: three instances with LATENCY 2, 3, 1.
module tb_dcache_responder;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    dcache_responder_if bus2();
    dcache_responder_if bus3();
    dcache_responder_if bus1();

    dcache_responder #(.DEPTH(512), .LATENCY(2)) u_l2 (.clock(clock), .reset(reset), .bus(bus2));
    dcache_responder #(.DEPTH(512), .LATENCY(3)) u_l3 (.clock(clock), .reset(reset), .bus(bus3));
    dcache_responder #(.DEPTH(512), .LATENCY(1)) u_l1 (.clock(clock), .reset(reset), .bus(bus1));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive2(input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [63:0] data);
        bus2.core2dcache_req       = 1'b1;
        bus2.core2dcache_data_we   = we;
        bus2.core2dcache_data_size = size;
        bus2.core2dcache_addr      = addr;
        bus2.core2dcache_data      = data;
    endtask

    // One transaction on the LATENCY=2 instance; called #1 after a posedge.
    task automatic xact2(input string tag, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [63:0] data,
                         input logic [63:0] exp_data, input logic exp_err);
        int n;
        drive2(we, size, addr, data);
        @(posedge clock); #1;
        bus2.core2dcache_req = 1'b0;
        n = 0;
        while (!bus2.dcache2core_data_valid && n < 20) begin
            chk({tag, ".busy"}, 64'(bus2.dcache_busy), 64'd1);
            @(posedge clock); #1;
            n++;
        end
        chk({tag, ".lat"}, 64'(n), 64'd1);
        chk({tag, ".data"}, bus2.dcache2core_data, exp_data);
        chk({tag, ".err"}, 64'(bus2.dcache2core_err), 64'(exp_err));
        @(posedge clock); #1;
        chk({tag, ".vdrop"}, {bus2.dcache2core_data[62:0], bus2.dcache2core_data_valid}, 64'd0);
    endtask

    initial begin
        bus2.core2dcache_req = 1'b0; bus2.core2dcache_addr = '0; bus2.core2dcache_data = '0;
        bus2.core2dcache_data_we = 1'b0; bus2.core2dcache_data_size = '0;
        bus3.core2dcache_req = 1'b0; bus3.core2dcache_addr = '0; bus3.core2dcache_data = '0;
        bus3.core2dcache_data_we = 1'b0; bus3.core2dcache_data_size = '0;
        bus1.core2dcache_req = 1'b0; bus1.core2dcache_addr = '0; bus1.core2dcache_data = '0;
        bus1.core2dcache_data_we = 1'b0; bus1.core2dcache_data_size = '0;

        // T1: reset held with req asserted
        reset = 1'b0;
        bus2.core2dcache_req = 1'b1;
        bus3.core2dcache_req = 1'b1;
        bus1.core2dcache_req = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst.valid2", 64'(bus2.dcache2core_data_valid), 64'd0);
        chk("rst.err2",   64'(bus2.dcache2core_err), 64'd0);
        chk("rst.busy2",  64'(bus2.dcache_busy), 64'd0);
        chk("rst.data2",  bus2.dcache2core_data, 64'd0);
        chk("rst.valid1", 64'(bus1.dcache2core_data_valid), 64'd0);
        chk("rst.busy3",  64'(bus3.dcache_busy), 64'd0);
        bus2.core2dcache_req = 1'b0;
        bus3.core2dcache_req = 1'b0;
        bus1.core2dcache_req = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("rst.post_busy2",  64'(bus2.dcache_busy), 64'd0);
        chk("rst.post_valid2", 64'(bus2.dcache2core_data_valid), 64'd0);
        chk("rst.post_busy3",  64'(bus3.dcache_busy), 64'd0);

        // T2: doubleword store then load
        xact2("sd10", 1'b1, 2'd3, 32'h10, 64'h1122334455667788, 64'd0, 1'b0);
        xact2("ld10", 1'b0, 2'd3, 32'h10, 64'd0, 64'h1122334455667788, 1'b0);

        // T3: byte store merges into the doubleword; narrow loads zero-extend
        xact2("sb13", 1'b1, 2'd0, 32'h13, 64'hAB, 64'd0, 1'b0);
        xact2("lw10", 1'b0, 2'd2, 32'h10, 64'd0, 64'h00000000AB667788, 1'b0);
        xact2("lh16", 1'b0, 2'd1, 32'h16, 64'd0, 64'h1122, 1'b0);
        xact2("lb17", 1'b0, 2'd0, 32'h17, 64'd0, 64'h11, 1'b0);

        // T4: errors leave the array untouched
        xact2("lw12", 1'b0, 2'd2, 32'h12, 64'd0, 64'd0, 1'b1);
        xact2("sd_oor", 1'b1, 2'd3, 32'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        xact2("sh11", 1'b1, 2'd1, 32'h11, 64'hFFFF, 64'd0, 1'b1);
        xact2("ld10b", 1'b0, 2'd3, 32'h10, 64'd0, 64'h11223344AB667788, 1'b0);
        xact2("sd_top", 1'b1, 2'd3, 32'hFF8, 64'hCAFEF00D12345678, 64'd0, 1'b0);
        xact2("ld_top", 1'b0, 2'd3, 32'hFF8, 64'd0, 64'hCAFEF00D12345678, 1'b0);
        xact2("lb_oor", 1'b0, 2'd0, 32'h1000, 64'd0, 64'd0, 1'b1);
        // store data above the access size must not leak into other bytes
        xact2("sw14", 1'b1, 2'd2, 32'h14, 64'hFFFFFFFF_CAFEBABE, 64'd0, 1'b0);
        xact2("ld10c", 1'b0, 2'd3, 32'h10, 64'd0, 64'hCAFEBABEAB667788, 1'b0);

        // T6: reset during WAIT drops a pending store
        xact2("sd20", 1'b1, 2'd3, 32'h20, 64'h0123456789ABCDEF, 64'd0, 1'b0);
        drive2(1'b1, 2'd3, 32'h20, 64'hDEAD);
        @(posedge clock); #1;
        bus2.core2dcache_req = 1'b0;
        chk("t6.busy_pre", 64'(bus2.dcache_busy), 64'd1);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        chk("t6.busy_rst", 64'(bus2.dcache_busy), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t6.novalid", 64'(bus2.dcache2core_data_valid), 64'd0);
            @(posedge clock); #1;
        end
        xact2("ld20", 1'b0, 2'd3, 32'h20, 64'd0, 64'h0123456789ABCDEF, 1'b0);

        // T5a: LATENCY=3 with req held high
        bus3.core2dcache_req       = 1'b1;
        bus3.core2dcache_data_we   = 1'b1;
        bus3.core2dcache_data_size = 2'd3;
        bus3.core2dcache_addr      = 32'h40;
        bus3.core2dcache_data      = 64'h1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            chk("l3.valid", 64'(bus3.dcache2core_data_valid), 64'((i % 3) == 2));
            chk("l3.busy",  64'(bus3.dcache_busy), 64'((i % 3) != 2));
            if ((i % 3) == 2) chk("l3.err", 64'(bus3.dcache2core_err), 64'd0);
        end
        bus3.core2dcache_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            chk("l3.drain", {62'd0, bus3.dcache2core_data_valid, bus3.dcache_busy}, 64'd0);
        end

        // T5b: LATENCY=3, extra req pulse during WAIT is not answered
        bus3.core2dcache_req = 1'b1;
        @(posedge clock); #1;            // accepted
        bus3.core2dcache_req = 1'b0;
        chk("l3p.w0", 64'(bus3.dcache_busy), 64'd1);
        @(posedge clock); #1;
        chk("l3p.w1", 64'(bus3.dcache_busy), 64'd1);
        bus3.core2dcache_req = 1'b1;     // pulse while waiting
        @(posedge clock); #1;
        bus3.core2dcache_req = 1'b0;
        chk("l3p.resp", 64'(bus3.dcache2core_data_valid), 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            chk("l3p.once", {62'd0, bus3.dcache2core_data_valid, bus3.dcache_busy}, 64'd0);
        end

        // T5c: LATENCY=1 answers every cycle and is never busy; a load right
        // after a store in RESP sees the stored value
        bus1.core2dcache_req       = 1'b1;
        bus1.core2dcache_data_we   = 1'b1;
        bus1.core2dcache_data_size = 2'd3;
        bus1.core2dcache_addr      = 32'h8;
        bus1.core2dcache_data      = 64'h5555AAAA12345678;
        @(posedge clock); #1;
        chk("l1.valid0", 64'(bus1.dcache2core_data_valid), 64'd1);
        bus1.core2dcache_data_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            chk("l1.valid", 64'(bus1.dcache2core_data_valid), 64'd1);
            chk("l1.busy",  64'(bus1.dcache_busy), 64'd0);
            chk("l1.data",  bus1.dcache2core_data, 64'h5555AAAA12345678);
        end
        bus1.core2dcache_req = 1'b0;
        @(posedge clock); #1;
        chk("l1.idle", 64'(bus1.dcache2core_data_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
